// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared constants for the instruction fetch unit: FSM state
//             encoding and the default reset PC.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

    // Default PC loaded on reset
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
//  Module   : next_pc_calc
//  Purpose  : Combinational redirect target computation for jr / j / branch.
//  Ports    : redir_br, redir_j, redir_jr - redirect requests from execute
//             ex_pc4   - pc_plus4 of the redirecting instruction
//             ex_imm16 - branch offset field (words, signed)
//             ex_tgt26 - jump target field (words)
//             ex_rs    - register value for jr
//             target   - selected redirect target
//             redirect - any redirect requested
//  Revision : 1.0 - initial release
// ============================================================================
module next_pc_calc (
    input  logic        redir_br,
    input  logic        redir_j,
    input  logic        redir_jr,
    input  logic [31:0] ex_pc4,
    input  logic [15:0] ex_imm16,
    input  logic [25:0] ex_tgt26,
    input  logic [31:0] ex_rs,
    output logic [31:0] target,
    output logic        redirect
);

    logic [31:0] w_br_off;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;

    // Sign-extended word offset converted to a byte offset
    assign w_br_off = {{14{ex_imm16[15]}}, ex_imm16, 2'b00};
    assign w_br_tgt = ex_pc4 + w_br_off;
    assign w_j_tgt  = {ex_pc4[31:28], ex_tgt26, 2'b00};

    // Priority: jr over j over branch
    always_comb begin
        target = w_br_tgt;
        if (redir_jr) begin
            target = ex_rs;
        end else if (redir_j) begin
            target = w_j_tgt;
        end
    end

    assign redirect = redir_br | redir_j | redir_jr;

endmodule : next_pc_calc
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Single-outstanding-request instruction fetch stage with a
//             one-entry hold register towards decode and redirect handling.
//  Ports    : clk, rst_n           - clock, async active-low reset
//             imem_req/addr        - memory request and word address
//             imem_ack/rdata       - memory response strobe and data
//             inst_valid/ready     - handshake to decode
//             inst, pc_plus4       - held instruction and its address + 4
//             redir_*/ex_*         - redirect requests and operands from execute
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc_plus4,
    input  logic        redir_br,
    input  logic        redir_j,
    input  logic        redir_jr,
    input  logic [31:0] ex_pc4,
    input  logic [15:0] ex_imm16,
    input  logic [25:0] ex_tgt26,
    input  logic [31:0] ex_rs
);

    logic [1:0]  r_state;
    logic [31:0] r_pc;        // architectural next-fetch PC
    logic [31:0] r_addr;      // address presented to memory; frozen while outstanding
    logic        r_discard;   // drop the response of the outstanding request
    logic [31:0] r_inst;
    logic [31:0] r_pc_plus4;

    logic [31:0] w_target;
    logic        w_redirect;
    logic [31:0] w_pc_inc;

    next_pc_calc u_next_pc_calc (
        .redir_br (redir_br),
        .redir_j  (redir_j),
        .redir_jr (redir_jr),
        .ex_pc4   (ex_pc4),
        .ex_imm16 (ex_imm16),
        .ex_tgt26 (ex_tgt26),
        .ex_rs    (ex_rs),
        .target   (w_target),
        .redirect (w_redirect)
    );

    assign w_pc_inc = r_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_discard  <= 1'b0;
            r_inst     <= 32'd0;
            r_pc_plus4 <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_redirect) begin
                        r_pc   <= w_target;
                        r_addr <= w_target;
                    end
                    r_state <= c_ST_REQ;
                end

                c_ST_REQ: begin
                    if (imem_ack && w_redirect) begin
                        // Response is stale; restart straight at the target
                        r_pc      <= w_target;
                        r_addr    <= w_target;
                        r_discard <= 1'b0;
                    end else if (imem_ack && r_discard) begin
                        // Stale response dropped; PC already holds the target
                        r_addr    <= r_pc;
                        r_discard <= 1'b0;
                    end else if (imem_ack) begin
                        r_inst     <= imem_rdata;
                        r_pc_plus4 <= w_pc_inc;
                        r_pc       <= w_pc_inc;
                        r_state    <= c_ST_HOLD;
                    end else if (w_redirect) begin
                        // Address must stay stable until the pending ack
                        r_pc      <= w_target;
                        r_discard <= 1'b1;
                    end
                end

                c_ST_HOLD: begin
                    if (w_redirect) begin
                        r_pc    <= w_target;
                        r_addr  <= w_target;
                        r_state <= c_ST_REQ;
                    end else if (inst_ready) begin
                        r_addr  <= r_pc;
                        r_state <= c_ST_REQ;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req   = (r_state == c_ST_REQ);
    assign inst_valid = (r_state == c_ST_HOLD);
    assign imem_addr  = r_addr;
    assign inst       = r_inst;
    assign pc_plus4   = r_pc_plus4;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed self-checking bench for fetch_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc_plus4;
    logic        redir_br;
    logic        redir_j;
    logic        redir_jr;
    logic [31:0] ex_pc4;
    logic [15:0] ex_imm16;
    logic [25:0] ex_tgt26;
    logic [31:0] ex_rs;

    int n_err;
    int n_chk;

    fetch_unit u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .pc_plus4   (pc_plus4),
        .redir_br   (redir_br),
        .redir_j    (redir_j),
        .redir_jr   (redir_jr),
        .ex_pc4     (ex_pc4),
        .ex_imm16   (ex_imm16),
        .ex_tgt26   (ex_tgt26),
        .ex_rs      (ex_rs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From REQ at addr: one wait cycle, then ack; ends in HOLD
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
        chk("req_on", {31'd0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, addr);
        step();
        chk("addr_stable", imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("valid_after_ack", {31'd0, inst_valid}, 32'd1);
        chk("inst", inst, data);
        chk("pc_plus4", pc_plus4, addr + 32'd4);
        chk("req_off_hold", {31'd0, imem_req}, 32'd0);
    endtask

    // Accept the held instruction; ends in REQ at next_addr
    task automatic accept(input logic [31:0] next_addr);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("valid_drop", {31'd0, inst_valid}, 32'd0);
        chk("next_addr", imem_addr, next_addr);
    endtask

    task automatic clear_redir();
        redir_br = 1'b0;
        redir_j  = 1'b0;
        redir_jr = 1'b0;
    endtask

    initial begin
        n_err      = 0;
        n_chk      = 0;
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        inst_ready = 1'b0;
        redir_br   = 1'b0;
        redir_j    = 1'b0;
        redir_jr   = 1'b0;
        ex_pc4     = 32'd0;
        ex_imm16   = 16'd0;
        ex_tgt26   = 26'd0;
        ex_rs      = 32'd0;

        // Reset values
        step();
        step();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc4", pc_plus4, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);

        // Release: one IDLE cycle (with a stray ack that must be ignored), then REQ
        rst_n    = 1'b1;
        imem_ack = 1'b1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        step();
        imem_ack = 1'b0;
        chk("idle_ack_ignored", {31'd0, inst_valid}, 32'd0);

        // Test 1: sequential fetch 0,4,8,12
        for (int i = 0; i < 4; i++) begin
            fetch_one(32'(i * 4), 32'h1000_0000 + 32'(i));
            accept(32'(i * 4 + 4));
        end

        // Test 2: backpressure for 5 cycles in HOLD
        fetch_one(32'h10, 32'h2222_0010);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", {31'd0, inst_valid}, 32'd1);
            chk("bp_inst", inst, 32'h2222_0010);
            chk("bp_pc4", pc_plus4, 32'h14);
            chk("bp_req", {31'd0, imem_req}, 32'd0);
        end
        accept(32'h14);

        // Test 3: branch redirect in HOLD (with inst_ready also high)
        fetch_one(32'h14, 32'h3333_0014);
        redir_br   = 1'b1;
        ex_pc4     = 32'h100;
        ex_imm16   = 16'hFFFE;
        inst_ready = 1'b1;
        step();
        clear_redir();
        inst_ready = 1'b0;
        chk("br_valid", {31'd0, inst_valid}, 32'd0);
        chk("br_addr", imem_addr, 32'hF8);
        fetch_one(32'hF8, 32'h4444_00F8);
        accept(32'hFC);

        // Test 4: jr while a request is outstanding, ack after 3 cycles
        redir_jr = 1'b1;
        ex_rs    = 32'h400;
        step();
        clear_redir();
        chk("jr_addr_hold", imem_addr, 32'hFC);
        chk("jr_req", {31'd0, imem_req}, 32'd1);
        step();
        chk("jr_addr_hold2", imem_addr, 32'hFC);
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_00FC;
        step();
        imem_ack = 1'b0;
        chk("jr_drop_valid", {31'd0, inst_valid}, 32'd0);
        chk("jr_target", imem_addr, 32'h400);
        step();
        chk("jr_still_req", {31'd0, inst_valid}, 32'd0);
        fetch_one(32'h400, 32'h5555_0400);

        // Test 5: j and br together in HOLD -> j wins
        redir_j  = 1'b1;
        redir_br = 1'b1;
        ex_pc4   = 32'hA000_0010;
        ex_tgt26 = 26'h10;
        ex_imm16 = 16'h0001;
        step();
        clear_redir();
        chk("j_valid", {31'd0, inst_valid}, 32'd0);
        chk("j_addr", imem_addr, 32'hA000_0040);

        // Redirect coincident with ack (jr beats j), target at top of memory
        redir_jr   = 1'b1;
        redir_j    = 1'b1;
        ex_rs      = 32'hFFFF_FFFC;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0040;
        step();
        clear_redir();
        imem_ack = 1'b0;
        chk("ackredir_valid", {31'd0, inst_valid}, 32'd0);
        chk("ackredir_addr", imem_addr, 32'hFFFF_FFFC);

        // PC wrap
        fetch_one(32'hFFFF_FFFC, 32'h6666_FFFC);
        accept(32'h0);
        fetch_one(32'h0, 32'h7777_0000);

        // Test 6: reset mid-HOLD takes effect immediately
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, inst_valid}, 32'd0);
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_inst", inst, 32'd0);
        chk("midrst_addr", imem_addr, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction memory request; held high until imem_ack.
REQ-005 imem_addr  output  32  word address of the current fetch (the PC).
REQ-006 imem_ack  input  1  memory response strobe; imem_rdata is valid in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 inst_valid  output  1  inst and pc_plus4 hold a fetched instruction for decode.
REQ-009 inst_ready  input  1  decode accepts the instruction this cycle.
REQ-010 inst  output  32  held instruction word.
REQ-011 pc_plus4  output  32  address of the held instruction plus 4.
REQ-012 redir_br  input  1  taken conditional branch from execute.
REQ-013 redir_j  input  1  j/jal from execute.
REQ-014 redir_jr  input  1  jr from execute.
REQ-015 ex_pc4  input  32  pc_plus4 of the redirecting instruction.
REQ-016 ex_imm16  input  16  branch offset field.
REQ-017 ex_tgt26  input  26  jump target field.
REQ-018 ex_rs  input  32  register value used by jr.

Function
REQ-019 States: IDLE, REQ, HOLD; the first cycle after reset release SHALL be IDLE, and the unit SHALL move unconditionally to REQ.
REQ-020 In REQ, imem_req SHALL be 1, and imem_addr SHALL stay equal to the PC and stable until imem_ack.
REQ-021 On imem_ack in REQ without a pending discard, the unit SHALL capture inst=imem_rdata and pc_plus4=PC+4, set PC=PC+4 and enter HOLD, so inst_valid rises in the following cycle (1-cycle fetch latency after ack).
REQ-022 In HOLD, inst_valid SHALL be 1 and imem_req 0; on inst_ready the unit SHALL enter REQ next cycle and deassert inst_valid.
REQ-023 Redirect target rules:
- jr: ex_rs.
- j: {ex_pc4[31:28], ex_tgt26, 2'b00}.
- br: ex_pc4 + (sign-extended ex_imm16 << 2), mod 2^32.
REQ-024 Redirect priority when several redirect inputs are asserted together: jr > j > br.
REQ-025 A redirect in HOLD SHALL load PC=target, discard the held instruction (regardless of inst_ready), clear inst_valid and enter REQ.
REQ-026 A redirect in REQ with the request still outstanding SHALL load PC=target and set a discard flag while imem_addr stays unchanged.
- The next imem_ack SHALL be dropped.
- The flag SHALL then clear, and the unit SHALL remain in REQ with imem_addr=target.
REQ-027 A redirect in the same cycle as imem_ack in REQ SHALL drop the ack data and reissue from the target next cycle.
REQ-028 A redirect in IDLE SHALL load PC=target before the first request.
REQ-029 A redirect SHALL have no effect on an instruction already accepted by decode.
REQ-030 PC arithmetic SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-031 imem_ack outside REQ SHALL be ignored.
REQ-032 At most one memory request SHALL be outstanding.

Reset
REQ-033 While rst_n=0, the unit SHALL be in IDLE with imem_req=0, inst_valid=0, inst=0, pc_plus4=0, discard flag=0 and PC=imem_addr=RESET_PC.
REQ-034 Reset asserted mid-request or mid-HOLD SHALL abort immediately with no output glitch beyond the reset values; an in-flight ack after release SHALL be ignored unless the unit is in REQ.

Structure
REQ-035 Package fetch_pkg SHALL hold the state encoding (IDLE=2'd0, REQ=2'd1, HOLD=2'd2) and the RESET_PC default.
REQ-036 Target computation SHALL be a combinational sub-module next_pc_calc (inputs: redirect flags, ex_pc4, ex_imm16, ex_tgt26, ex_rs; outputs: target, redirect).

Verification
REQ-037 Test 1, sequential fetch:
- Stimulus: reset release, ack 1 cycle after each request, inst_ready=1.
- Required: addresses 0, 4, 8, 12; inst_valid one cycle after each ack.
REQ-038 Test 2, backpressure:
- Stimulus: inst_ready=0 for 5 cycles in HOLD.
- Required: inst/pc_plus4 stable, imem_req=0, no new request until ready.
REQ-039 Test 3, branch redirect:
- Stimulus: redir_br with ex_pc4=32'h100, ex_imm16=16'hFFFE, in HOLD.
- Required: held instruction dropped; next imem_addr=32'hF8.
REQ-040 Test 4, redirect with outstanding request:
- Stimulus: redir_jr with ex_rs=32'h400 while a request is outstanding with a 3-cycle ack.
- Required: first ack ignored, inst_valid stays 0, then a request at 32'h400.
REQ-041 Test 5, priority and jump target:
- Stimulus: redir_j and redir_br together, ex_pc4=32'hA000_0010, ex_tgt26=26'h10.
- Required: imem_addr=32'hA000_0040.
REQ-042 Test 6, reset mid-HOLD:
- Stimulus: reset asserted while in HOLD.
- Required: inst_valid=0 immediately, and after release imem_addr=RESET_PC.
